// File: rtl/avalon_mem_port.sv
// avalon_mem_port: Avalon-MM master for the multicycle MIPS core. Turns the
// control decoder's MemRead/MemWrite/IorD strobes into a single Avalon read or
// write. It holds the sequencer with stall until the transfer finishes, and it
// drives byte lanes for sub-word loads and stores.
//
// Build option: define AVMEM_BYTESWAP_EN for a big-endian memory. readdata and
// writedata are then byte-reversed at the bus boundary, and the byte lanes are
// mirrored.
//
// Ports:
//   clk, reset_n             clock and synchronous active-low reset
//   mem_read, mem_write      MemRead / MemWrite strobes (write wins if both)
//   iord                     0 = instruction fetch, 1 = data access
//   opcode                   IR[31:26], selects size and extension
//   addr                     byte address
//   store_data               rt value for stores
//   rt_old                   current rt, merged by LWL/LWR
//   stall                    sequencer hold (combinational)
//   raw_data                 latched readdata, unformatted
//   load_data                extended / merged load result
//   load_valid               one-cycle pulse in DONE
//   addr_error, bus_error    sticky misalignment / timeout flags
//   address, read, write, byteenable, writedata, waitrequest, readdata
//                            Avalon-MM master side
module avalon_mem_port #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        iord,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic        stall,
  output logic [31:0] raw_data,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_error,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUS,
    S_DONE,
    S_HALT
  } state_t;

  // Access class: K_WORD has no alignment check, K_WORD_AL must be aligned.
  typedef enum logic [2:0] {
    K_WORD,
    K_WORD_AL,
    K_BYTE,
    K_HALF,
    K_LWL,
    K_LWR
  } kind_t;

  state_t            state_q, state_d;
  kind_t             kind_q, kind_d, kind_c;
  logic              sext_q, sext_d, sext_c;
  logic [1:0]        lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       load_q, load_q_d;

  logic              read_d, write_d, load_valid_d, addr_error_d, bus_error_d;
  logic [31:0]       address_d, writedata_d, raw_data_d;
  logic [3:0]        byteenable_d;

  logic              req_c, misaligned_c;
  logic [3:0]        be_le_c, be_c;
  logic [31:0]       wdata_le_c, wdata_c, rdata_c, fmt_c;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Request decode: access class and extension from the opcode.
  always_comb begin
    kind_c = K_WORD;
    sext_c = 1'b0;
    if (!iord) begin
      kind_c = K_WORD_AL;
    end else begin
      case (opcode)
        OP_LB:          begin kind_c = K_BYTE; sext_c = 1'b1; end
        OP_LBU, OP_SB:  kind_c = K_BYTE;
        OP_LH:          begin kind_c = K_HALF; sext_c = 1'b1; end
        OP_LHU, OP_SH:  kind_c = K_HALF;
        OP_LW, OP_SW:   kind_c = K_WORD_AL;
        OP_LWL:         kind_c = K_LWL;
        OP_LWR:         kind_c = K_LWR;
        default:        kind_c = K_WORD;
      endcase
    end
  end

  assign req_c        = mem_read | mem_write;
  assign misaligned_c = ((kind_c == K_WORD_AL) && (addr[1:0] != 2'b00)) ||
                        ((kind_c == K_HALF) && addr[0]);

  // Little-endian lane mask and replicated store data.
  always_comb begin
    be_le_c    = 4'b1111;
    wdata_le_c = store_data;
    case (kind_c)
      K_BYTE: begin
        be_le_c    = 4'b0001 << addr[1:0];
        wdata_le_c = {4{store_data[7:0]}};
      end
      K_HALF: begin
        be_le_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_le_c = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef AVMEM_BYTESWAP_EN
  // Big-endian memory: mirror lanes (index 3-a) and reverse bytes on the bus.
  assign be_c    = {be_le_c[0], be_le_c[1], be_le_c[2], be_le_c[3]};
  assign wdata_c = {wdata_le_c[7:0], wdata_le_c[15:8], wdata_le_c[23:16], wdata_le_c[31:24]};
  assign rdata_c = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
`else
  assign be_c    = be_le_c;
  assign wdata_c = wdata_le_c;
  assign rdata_c = readdata;
`endif

  // Load formatting from the latched word and the access lane.
  always_comb begin
    byte_sel = raw_data[7:0];
    case (lane_q)
      2'd1:    byte_sel = raw_data[15:8];
      2'd2:    byte_sel = raw_data[23:16];
      2'd3:    byte_sel = raw_data[31:24];
      default: byte_sel = raw_data[7:0];
    endcase
    half_sel = lane_q[1] ? raw_data[31:16] : raw_data[15:0];
    fmt_c    = raw_data;
    case (kind_q)
      K_BYTE: fmt_c = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
      K_HALF: fmt_c = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
      K_LWL: begin
        case (lane_q)
          2'd0:    fmt_c = {raw_data[7:0],  rt_old[23:0]};
          2'd1:    fmt_c = {raw_data[15:0], rt_old[15:0]};
          2'd2:    fmt_c = {raw_data[23:0], rt_old[7:0]};
          default: fmt_c = raw_data;
        endcase
      end
      K_LWR: begin
        case (lane_q)
          2'd1:    fmt_c = {rt_old[31:24], raw_data[31:8]};
          2'd2:    fmt_c = {rt_old[31:16], raw_data[31:16]};
          2'd3:    fmt_c = {rt_old[31:8],  raw_data[31:24]};
          default: fmt_c = raw_data;
        endcase
      end
      default: ;
    endcase
  end

  // rt_old is only merged while in DONE; afterwards the captured result holds.
  assign load_data = (state_q == S_DONE) ? fmt_c : load_q;
  assign stall     = ((state_q == S_IDLE) && req_c) || (state_q == S_BUS) ||
                     (state_q == S_HALT);

  // Next-state and next-register logic.
  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    sext_d       = sext_q;
    lane_d       = lane_q;
    cnt_d        = cnt_q;
    load_q_d     = load_q;
    read_d       = read;
    write_d      = write;
    address_d    = address;
    byteenable_d = byteenable;
    writedata_d  = writedata;
    raw_data_d   = raw_data;
    load_valid_d = 1'b0;
    addr_error_d = addr_error;
    bus_error_d  = bus_error;
    case (state_q)
      S_IDLE: begin
        if (req_c) begin
          if (misaligned_c) begin
            state_d      = S_HALT;
            addr_error_d = 1'b1;
          end else begin
            state_d      = S_BUS;
            read_d       = ~mem_write;
            write_d      = mem_write;
            address_d    = {addr[31:2], 2'b00};
            byteenable_d = be_c;
            writedata_d  = wdata_c;
            kind_d       = kind_c;
            sext_d       = sext_c;
            lane_d       = addr[1:0];
            cnt_d        = '0;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          state_d      = S_DONE;
          read_d       = 1'b0;
          write_d      = 1'b0;
          load_valid_d = 1'b1;
          if (read) raw_data_d = rdata_c;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1))) begin
          state_d     = S_HALT;
          read_d      = 1'b0;
          write_d     = 1'b0;
          bus_error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        load_q_d = fmt_c;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      kind_q     <= K_WORD;
      sext_q     <= 1'b0;
      lane_q     <= 2'b00;
      cnt_q      <= '0;
      load_q     <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      byteenable <= '0;
      writedata  <= '0;
      raw_data   <= '0;
      load_valid <= 1'b0;
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      sext_q     <= sext_d;
      lane_q     <= lane_d;
      cnt_q      <= cnt_d;
      load_q     <= load_q_d;
      read       <= read_d;
      write      <= write_d;
      address    <= address_d;
      byteenable <= byteenable_d;
      writedata  <= writedata_d;
      raw_data   <= raw_data_d;
      load_valid <= load_valid_d;
      addr_error <= addr_error_d;
      bus_error  <= bus_error_d;
    end
  end

endmodule

// File: doc/avalon_mem_port.md
# avalon_mem_port

Data-side and fetch-side Avalon-MM master for the multicycle MIPS core, sitting directly downstream of the control decoder. It converts the decoder's MemRead/MemWrite/IorD strobes into one Avalon read or write and holds the state sequencer with `stall` until `waitrequest` clears. It drives byte lanes for LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW and returns both the raw word (for IR/fetch) and the formatted load value (for the MDR/write-back path).

## Interface
- `WAIT_TIMEOUT`, default 255: maximum consecutive `waitrequest` cycles before bus error; 0 disables the timeout.
- `clk`  in  1  — single clock; all state updates on its rising edge.
- `reset_n`  in  1  — synchronous, active-low reset.
- `mem_read`  in  1  — MemRead from control.
- `mem_write`  in  1  — MemWrite from control.
- `iord`  in  1  — 0 = instruction fetch (word read, opcode ignored); 1 = data access.
- `opcode`  in  6  — IR[31:26]; selects access size and extension.
- `addr`  in  32  — byte address (PC or ALUOut after the IorD mux).
- `store_data`  in  32  — rt value for stores.
- `rt_old`  in  32  — current rt contents, used for the LWL/LWR merge.
- `stall`  out  1  — sequencer must hold its state while high.
- `raw_data`  out  32  — latched `readdata`, unformatted.
- `load_data`  out  32  — extended or merged load result.
- `load_valid`  out  1  — one-cycle pulse; `raw_data`/`load_data` are valid.
- `addr_error`  out  1  — sticky misaligned-access flag.
- `bus_error`  out  1  — sticky timeout flag.
- `address`  out  32  — Avalon word address: {addr[31:2], 2'b00}.
- `read`, `write`  out  1 each — Avalon strobes.
- `byteenable`  out  4.
- `writedata`  out  32.
- `waitrequest`  in  1.
- `readdata`  in  32.

## Operation
- FSM states and transitions:
  - IDLE: request = `mem_read` | `mem_write`. If the request is legal, go to BUS. If misaligned, go to HALT with `addr_error`=1.
  - BUS: hold `read`/`write`. Go to DONE on `waitrequest`=0. Go to HALT with `bus_error`=1 if the timeout expires.
  - DONE: go to IDLE unconditionally. Never re-launches from DONE, even if the strobes are still high.
  - HALT: `stall`=1 permanently until reset.
- In IDLE, `address`, `byteenable`, `writedata`, the access type and addr[1:0] are registered on the request. They stay constant throughout BUS regardless of input changes.
- `mem_read` and `mem_write` both high: write wins.
- Fetch (`iord`=0): `byteenable`=1111, addr[1:0] must be 00.
- Byte lanes, little-endian, a = addr[1:0]:
  - LB/LBU/SB: `byteenable` = 1<<a.
  - LH/LHU/SH: a[0] must be 0; `byteenable` = 0011 (a=0) or 1100 (a=2).
  - LW/SW: a must be 00; `byteenable` = 1111.
  - LWL/LWR: `byteenable` = 1111 for any a.
- Write data:
  - SB: {4{rt[7:0]}}.
  - SH: {2{rt[15:0]}}.
  - SW: rt.
- Load formatting, with w = latched word:
  - LB/LBU: byte a, sign- or zero-extended.
  - LH/LHU: halfword a[1], sign- or zero-extended.
  - LW: w.
  - LWL: a=0 {w[7:0],rt[23:0]}; a=1 {w[15:0],rt[15:0]}; a=2 {w[23:0],rt[7:0]}; a=3 w.
  - LWR: a=0 w; a=1 {rt[31:24],w[31:8]}; a=2 {rt[31:16],w[31:16]}; a=3 {rt[31:8],w[31:24]}.
- `rt_old` is sampled in DONE.
- Any other opcode with `iord`=1: word read or write, no alignment check.

## Timing
- `stall` = (IDLE & request) | BUS | HALT. It is combinational, so the sequencer is frozen in the same cycle the request appears.
- Minimum access is 3 cycles: request seen in IDLE (cycle 0), one BUS cycle with `waitrequest`=0 (cycle 1), DONE (cycle 2).
- In DONE: `load_valid`=1 and `stall`=0, so the sequencer advances at the end of DONE.
- `readdata` is sampled on the BUS cycle where `read`=1 and `waitrequest`=0. Writes complete on the same condition.
- Each extra `waitrequest` cycle adds exactly one cycle of latency.
- Timeout: counter clears on entering BUS. After WAIT_TIMEOUT consecutive `waitrequest`=1 cycles, `read`/`write` drop on the next edge.
- Reset values, applied on the edge where `reset_n`=0, including mid-BUS:
  - state = IDLE.
  - `read`, `write`, `load_valid`, `addr_error`, `bus_error` = 0.
  - `address`, `byteenable`, `writedata`, `raw_data`, `load_data` = 0.
  - Counter = 0.

## Configuration
- `AVMEM_BYTESWAP_EN` defined: memory is big-endian.
  - `readdata` and `writedata` are byte-reversed at the bus boundary.
  - Lane index becomes 3-a for the `byteenable` computation.
- Not defined: no swap, little-endian lanes exactly as above.

## Test plan
- Fetch, `iord`=0, `addr`=0x1000, `waitrequest` low, `readdata`=0x24080005 → `address`=0x1000, `read`=1 for 1 cycle, `byteenable`=1111, DONE `raw_data`=0x24080005, 3 cycles total.
- LB, `addr`=0x2003, `readdata`=0x80FFFFFF, `waitrequest` high 4 cycles → `byteenable`=1000, `stall` high 6 cycles, `load_data`=0xFFFFFF80; same case with LBU → 0x00000080.
- SH, `addr`=0x2002, `store_data`=0x1234ABCD → `write`=1, `byteenable`=1100, `writedata`=0xABCDABCD; LH at 0x2001 → no bus cycle, `addr_error`=1, `stall` stuck high.
- LWL, `addr`=0x3001, `rt_old`=0x11223344, `readdata`=0xAABBCCDD → `load_data`=0xCCDD3344; LWR at the same inputs → 0x11AABBCC.
- `WAIT_TIMEOUT`=8 with `waitrequest` held high → `read` drops after 8 BUS cycles, `bus_error`=1; `reset_n` low mid-BUS on another run → `read`=0 and IDLE after 1 edge.
- With `AVMEM_BYTESWAP_EN`: SB `addr`=0x0, `store_data`=0xEF → `byteenable`=1000; LW `readdata`=0x11223344 → `load_data`=0x44332211.
